// File: rtl/bram_client_pkg.sv
// Shared constants and sizing helpers for the BRAM read client and its response FIFO.
package bram_client_pkg;

    localparam int RSP_DEPTH_MIN = 2;
    localparam int RSP_DEPTH_MAX = 16;

    // Occupancy must be able to represent every value from 0 up to and including depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= RSP_DEPTH_MIN) && (depth <= RSP_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Register-based response FIFO; pointers wrap at RSP_DEPTH so any depth in range is allowed.
// A dequeue request while empty is ignored.
module bram_rsp_fifo
    import bram_client_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enq,
    input  logic [DATA_W-1:0]                    enq_data,
    input  logic                                 deq,
    output logic [occ_width(RSP_DEPTH)-1:0]      occ,
    output logic [DATA_W-1:0]                    head_data
);

    localparam int OCC_W = occ_width(RSP_DEPTH);
    localparam int PTR_W = ptr_width(RSP_DEPTH);

    logic [DATA_W-1:0] storage [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_deq;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_deq    = deq && (occ != '0);
    assign head_data = storage[rd_ptr];

    // Data storage and write pointer; all entries clear on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                storage[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (enq) begin
            storage[wr_ptr] <= enq_data;
            wr_ptr          <= ptr_next(wr_ptr);
        end
    end

    // Read pointer and occupancy; a simultaneous enqueue and dequeue leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_deq) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({enq, do_deq})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/bram_read_client.sv
// Requester side of a one-cycle-latency BRAM read port: turns a valid/ready address stream
// into read strobes and buffers returned words so a stalled consumer never loses data.
// Optional macro BRAM_READ_CLIENT_BYPASS_EN: forwards the returning word straight to the
// response port when the FIFO is empty, cutting latency from two cycles to one.
module bram_read_client
    import bram_client_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int RSP_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              bram_read_en,
    output logic [ADDR_W-1:0] bram_read_addr,
    input  logic [DATA_W-1:0] bram_read_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data
);

    localparam int OCC_W = occ_width(RSP_DEPTH);

    if (!depth_legal(RSP_DEPTH)) begin : g_bad_depth
        $error("bram_read_client: RSP_DEPTH outside legal range");
    end

    logic              inflight;
    logic              accept;
    logic              enq;
    logic              deq;
    logic              fifo_valid;
    logic              credit_ok;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    pending;
    logic [DATA_W-1:0] head_data;
`ifdef BRAM_READ_CLIENT_BYPASS_EN
    logic              bypass_hit;
`endif

    // A request is only granted when the FIFO has room for every read already in flight,
    // so the returning word always has a slot; reset also blocks strobes while held.
    assign pending        = {1'b0, occ} + (OCC_W + 1)'(inflight);
    assign credit_ok      = pending < (OCC_W + 1)'(RSP_DEPTH);
    assign req_ready      = credit_ok && RST_N;
    assign accept         = req_valid && req_ready;
    assign bram_read_en   = accept;
    assign bram_read_addr = req_addr;

    // Remembers that a strobe went out, so the data arriving this cycle gets captured.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
        end
    end

    // Response selection and FIFO control, with the optional empty-FIFO bypass.
    always_comb begin
        fifo_valid = (occ != '0);
        deq        = fifo_valid && rsp_ready;
        rsp_valid  = fifo_valid;
        rsp_data   = head_data;
        enq        = inflight;
`ifdef BRAM_READ_CLIENT_BYPASS_EN
        bypass_hit = !fifo_valid && inflight;
        if (bypass_hit) begin
            rsp_valid = 1'b1;
            rsp_data  = bram_read_data;
            enq       = !rsp_ready;
        end
`endif
    end

    bram_rsp_fifo #(
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .enq       (enq),
        .enq_data  (bram_read_data),
        .deq       (deq),
        .occ       (occ),
        .head_data (head_data)
    );

endmodule

// File: tb/tb_bram_read_client.sv
// Self-checking bench for bram_read_client: a depth-4 instance for the main tests and a
// depth-2 instance for the throughput pattern. Honours BRAM_READ_CLIENT_BYPASS_EN.
module tb_bram_read_client;

`ifdef BRAM_READ_CLIENT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_addr;
    logic        bram_read_en;
    logic [8:0]  bram_read_addr;
    logic [31:0] bram_read_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    logic        req_valid2;
    logic        req_ready2;
    logic [8:0]  req_addr2;
    logic        bram_read_en2;
    logic [8:0]  bram_read_addr2;
    logic [31:0] bram_read_data2;
    logic        rsp_valid2;
    logic        rsp_ready2;
    logic [31:0] rsp_data2;

    logic [31:0] mem [512];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req_valid;
        logic [8:0]  req_addr;
        logic        rsp_ready;
        logic        exp_req_ready;
        logic        exp_read_en;
        logic        exp_rsp_valid;
        logic [31:0] exp_rsp_data;
        int          exp_occ;
    } vec_t;

    vec_t vecs [14];

    bram_read_client #(.DATA_W(32), .ADDR_W(9), .RSP_DEPTH(4)) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .bram_read_en   (bram_read_en),
        .bram_read_addr (bram_read_addr),
        .bram_read_data (bram_read_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data)
    );

    bram_read_client #(.DATA_W(32), .ADDR_W(9), .RSP_DEPTH(2)) dut2 (
        .CLK            (clk),
        .RST_N          (rst_n),
        .req_valid      (req_valid2),
        .req_ready      (req_ready2),
        .req_addr       (req_addr2),
        .bram_read_en   (bram_read_en2),
        .bram_read_addr (bram_read_addr2),
        .bram_read_data (bram_read_data2),
        .rsp_valid      (rsp_valid2),
        .rsp_ready      (rsp_ready2),
        .rsp_data       (rsp_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents: A5A5_0000 | address, except address 5 which holds DEADBEEF.
    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = 32'hA5A5_0000 | i;
        end
        mem[5] = 32'hDEAD_BEEF;
    end

    // One-cycle registered-read BRAM models, one per DUT.
    always @(posedge clk) begin
        if (bram_read_en) bram_read_data <= mem[bram_read_addr];
        if (bram_read_en2) bram_read_data2 <= mem[bram_read_addr2];
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [8:0] a, input logic rr);
        @(posedge clk);
        #1;
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        int          nresp;
        int          exp_idx;
        logic [8:0]  q2 [$];
        logic [8:0]  head;

        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 9'h005;
        rsp_ready  = 1'b1;
        req_valid2 = 1'b0;
        req_addr2  = '0;
        rsp_ready2 = 1'b1;

        // Backpressure table: addresses 10..15, consumer stalled then draining.
        vecs[0]  = '{1'b1, 9'd10, 1'b0, 1'b1, 1'b1, 1'b0,   32'h0,         0};
        vecs[1]  = '{1'b1, 9'd11, 1'b0, 1'b1, 1'b1, BYPASS, 32'hA5A5_000A, 0};
        vecs[2]  = '{1'b1, 9'd12, 1'b0, 1'b1, 1'b1, 1'b1,   32'hA5A5_000A, 1};
        vecs[3]  = '{1'b1, 9'd13, 1'b0, 1'b1, 1'b1, 1'b1,   32'hA5A5_000A, 2};
        vecs[4]  = '{1'b1, 9'd14, 1'b0, 1'b0, 1'b0, 1'b1,   32'hA5A5_000A, 3};
        vecs[5]  = '{1'b1, 9'd14, 1'b0, 1'b0, 1'b0, 1'b1,   32'hA5A5_000A, 4};
        vecs[6]  = '{1'b1, 9'd14, 1'b1, 1'b0, 1'b0, 1'b1,   32'hA5A5_000A, 4};
        vecs[7]  = '{1'b1, 9'd14, 1'b0, 1'b1, 1'b1, 1'b1,   32'hA5A5_000B, 3};
        vecs[8]  = '{1'b1, 9'd15, 1'b0, 1'b0, 1'b0, 1'b1,   32'hA5A5_000B, 3};
        vecs[9]  = '{1'b0, 9'd0,  1'b1, 1'b0, 1'b0, 1'b1,   32'hA5A5_000B, 4};
        vecs[10] = '{1'b0, 9'd0,  1'b1, 1'b1, 1'b0, 1'b1,   32'hA5A5_000C, 3};
        vecs[11] = '{1'b0, 9'd0,  1'b1, 1'b1, 1'b0, 1'b1,   32'hA5A5_000D, 2};
        vecs[12] = '{1'b0, 9'd0,  1'b1, 1'b1, 1'b0, 1'b1,   32'hA5A5_000E, 1};
        vecs[13] = '{1'b0, 9'd0,  1'b1, 1'b1, 1'b0, 1'b0,   32'h0,         0};

        // 1. Reset held with a request pending.
        repeat (3) @(negedge clk);
        checkOutput("rst_read_en", bram_read_en, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        checkOutput("rel_req_ready", req_ready, 1);
        checkOutput("rel_rsp_valid", rsp_valid, 0);

        // 2. Single read of address 5.
        applyStimulus(1'b1, 9'h005, 1'b1);
        @(negedge clk);
        checkOutput("single_read_en", bram_read_en, 1);
        checkOutput("single_read_addr", bram_read_addr, 9'h005);
        applyStimulus(1'b0, 9'h000, 1'b1);
        @(negedge clk);
        checkOutput("single_t1_valid", rsp_valid, BYPASS);
        if (BYPASS) checkOutput("single_t1_data", rsp_data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 9'h000, 1'b1);
        @(negedge clk);
        checkOutput("single_t2_valid", rsp_valid, !BYPASS);
        if (!BYPASS) checkOutput("single_t2_data", rsp_data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 9'h000, 1'b1);
        @(negedge clk);
        checkOutput("single_t3_valid", rsp_valid, 0);

        // 3. Streaming addresses 0..31 with the consumer always ready.
        nresp = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(i < 32, 9'(i), 1'b1);
            @(negedge clk);
            if (i < 32) checkOutput("stream_req_ready", req_ready, 1);
            if (rsp_valid) begin
                checkOutput("stream_data", rsp_data, mem[nresp]);
                nresp++;
            end
        end
        checkOutput("stream_count", nresp, 32);

        // 4. Backpressure, full FIFO and credit return, table driven.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].req_valid, vecs[i].req_addr, vecs[i].rsp_ready);
            @(negedge clk);
            checkOutput($sformatf("bp%0d_req_ready", i), req_ready, vecs[i].exp_req_ready);
            checkOutput($sformatf("bp%0d_read_en", i), bram_read_en, vecs[i].exp_read_en);
            checkOutput($sformatf("bp%0d_rsp_valid", i), rsp_valid, vecs[i].exp_rsp_valid);
            if (vecs[i].exp_rsp_valid) begin
                checkOutput($sformatf("bp%0d_rsp_data", i), rsp_data, vecs[i].exp_rsp_data);
            end
            checkOutput($sformatf("bp%0d_occ", i), 32'(dut.occ), vecs[i].exp_occ);
        end

        // 5. Reset asserted while a read is in flight.
        applyStimulus(1'b1, 9'h001, 1'b0);
        applyStimulus(1'b1, 9'h002, 1'b0);
        applyStimulus(1'b1, 9'h003, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        checkOutput("midrst_rsp_data", rsp_data, 0);
        checkOutput("midrst_occ", 32'(dut.occ), 0);
        checkOutput("midrst_read_en", bram_read_en, 0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postrst_occ", 32'(dut.occ), 0);
        checkOutput("postrst_rsp_valid", rsp_valid, 0);
        checkOutput("postrst_req_ready", req_ready, 1);
        applyStimulus(1'b1, 9'h01F, 1'b1);
        @(negedge clk);
        checkOutput("postrst_read_en", bram_read_en, 1);
        applyStimulus(1'b0, 9'h000, 1'b1);
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                checkOutput("postrst_data", rsp_data, 32'hA5A5_001F);
                nresp++;
            end
        end
        checkOutput("postrst_count", nresp, 1);

        // 6. Depth-2 instance: accept pattern and response order.
        exp_idx = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            req_valid2 = (i < 9);
            req_addr2  = 9'(40 + i);
            @(negedge clk);
            if (i < 9) begin
                checkOutput($sformatf("d2_accept%0d", i), req_valid2 & req_ready2,
                            (BYPASS || (i % 3 != 2)) ? 1 : 0);
            end
            if (rsp_valid2) begin
                if (q2.size() == 0) begin
                    checkOutput("d2_unexpected_rsp", 1, 0);
                end else begin
                    head = q2.pop_front();
                    checkOutput("d2_rsp_data", rsp_data2, 32'hA5A5_0000 | 32'(head));
                end
            end
            if (req_valid2 && req_ready2) begin
                q2.push_back(req_addr2);
                exp_idx++;
            end
        end
        checkOutput("d2_accept_total", exp_idx, BYPASS ? 9 : 6);
        checkOutput("d2_all_returned", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
